// File: rtl/seg7_scan_driver_if.sv
// Capture bus from the upstream 4-bit ALU stage into the seven-segment driver.
// The ALU side drives it (master); the display driver samples it (slave).
interface seg7_scan_driver_if;
  logic       load;    // capture strobe
  logic [3:0] in_1;    // operand A
  logic [3:0] in_2;    // operand B
  logic [2:0] sel;     // operation select
  logic       En;      // ALU enable
  logic [3:0] result;  // ALU output

  modport master (output load, in_1, in_2, sel, En, result);
  modport slave  (input  load, in_1, in_2, sel, En, result);
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver for an ALU transaction.
// Digit 3 = operand A, digit 2 = operand B, digit 1 = select, digit 0 = result
// (or a dash when the ALU was disabled). Each digit slot starts with one
// all-off cycle to avoid ghosting. Outputs come straight from flops.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_driver_if.slave   alu,
  output logic [3:0]          an,
  output logic [6:0]          seg
);

  localparam int             CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(REFRESH_DIV - 1);
  // Active-low patterns; polarity is applied once at the output stage.
  localparam logic [3:0]     AN_OFF_LO  = 4'b1111;
  localparam logic [6:0]     SEG_OFF_LO = 7'b1111111;
  localparam logic [6:0]     SEG_DASH_LO = 7'b0111111;
  localparam logic [3:0]     BLANK_AN  = COMMON_ANODE ? AN_OFF_LO  : ~AN_OFF_LO;
  localparam logic [6:0]     BLANK_SEG = COMMON_ANODE ? SEG_OFF_LO : ~SEG_OFF_LO;

  // Captured ALU transaction
  logic [3:0]    a_q, a_d;
  logic [3:0]    b_q, b_d;
  logic [2:0]    s_q, s_d;
  logic          en_q, en_d;
  logic [3:0]    r_q, r_d;

  // Scan position
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;

  // Output registers
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  // Working signals
  logic          slot_wrap;
  logic          blank_now;
  logic [3:0]    an_lit_lo;
  logic [6:0]    digit_lo;

  // Hex digit to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_lo(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'b1000000;
      4'h1:    p = 7'b1111001;
      4'h2:    p = 7'b0100100;
      4'h3:    p = 7'b0110000;
      4'h4:    p = 7'b0011001;
      4'h5:    p = 7'b0010010;
      4'h6:    p = 7'b0000010;
      4'h7:    p = 7'b1111000;
      4'h8:    p = 7'b0000000;
      4'h9:    p = 7'b0010000;
      4'hA:    p = 7'b0001000;
      4'hB:    p = 7'b0000011;
      4'hC:    p = 7'b1000110;
      4'hD:    p = 7'b0100001;
      4'hE:    p = 7'b0000110;
      default: p = 7'b0001110;
    endcase
    return p;
  endfunction

  // One-hot-low digit enable for the current slot index.
  for (genvar gi = 0; gi < 4; gi++) begin : g_an
    assign an_lit_lo[gi] = (idx_q != 2'(gi));
  end

  // Capture register next-state: load all five fields together, else hold.
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    s_d  = s_q;
    en_d = en_q;
    r_d  = r_q;
    if (alu.load) begin
      a_d  = alu.in_1;
      b_d  = alu.in_2;
      s_d  = alu.sel;
      en_d = alu.En;
      r_d  = alu.result;
    end
  end

  // Slot counter and digit index; the index steps when the counter wraps.
  always_comb begin
    slot_wrap = (cnt_q == CNT_MAX);
    cnt_d     = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d     = slot_wrap ? idx_q + 2'd1 : idx_q;
  end

  // Output next-state from the pre-edge scan position and captured values, so
  // a capture at edge k shows from edge k+1 and the slot's first cycle is blank.
  always_comb begin
    blank_now = (cnt_q == '0);
    case (idx_q)
      2'd3:    digit_lo = hex_lo(a_q);
      2'd2:    digit_lo = hex_lo(b_q);
      2'd1:    digit_lo = hex_lo({1'b0, s_q});
      default: digit_lo = en_q ? hex_lo(r_q) : SEG_DASH_LO;
    endcase
    if (blank_now) begin
      an_d  = BLANK_AN;
      seg_d = BLANK_SEG;
    end else begin
      an_d  = COMMON_ANODE ? an_lit_lo : ~an_lit_lo;
      seg_d = COMMON_ANODE ? digit_lo  : ~digit_lo;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      en_q  <= 1'b0;
      r_q   <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= BLANK_AN;
      seg_q <= BLANK_SEG;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      en_q  <= en_d;
      r_q   <= r_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
